// File: rtl/ret_stack_ctrl.sv
// Return-address stack for the 19-bit CPU: call pushes PC+1, return pops the
// top entry with zero latency, with sticky overflow/underflow and a flush path.
module ret_stack_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 19
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_addr,
    input  logic                         flush,
    input  logic                         clr_err,
    output logic [AW-1:0]                top_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_ZERO = SPW'(0);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [AW-1:0]  mem_q [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    logic [IW-1:0]  sp_lo_s;
    logic [IW-1:0]  top_idx_s;
    logic [IW-1:0]  wr_idx_s;
    logic           wr_en_s;
    logic           empty_s;
    logic           full_s;

    // At sp == DEPTH the low bits are zero, so sp_lo - 1 still lands on DEPTH-1.
    assign sp_lo_s   = sp_q[IW-1:0];
    assign top_idx_s = sp_lo_s - IW'(1);
    assign empty_s   = (sp_q == SP_ZERO);
    assign full_s    = (sp_q == SP_FULL);

    // Next-state: flush beats push/pop; clr_err runs in parallel and loses to a set.
    always_comb begin
        sp_d     = sp_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        wr_en_s  = 1'b0;
        wr_idx_s = '0;

        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
            udf_d = udf_q;
        end

        if (flush) begin
            sp_d = SP_ZERO;
        end else if (push && pop) begin
            wr_en_s = 1'b1;
            if (empty_s) begin
                wr_idx_s = '0;
                sp_d     = SP_ONE;
                udf_d    = 1'b1;
            end else begin
                wr_idx_s = top_idx_s;
            end
        end else if (push) begin
            if (full_s) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_s  = 1'b1;
                wr_idx_s = sp_lo_s;
                sp_d     = sp_q + SP_ONE;
            end
        end else if (pop) begin
            if (empty_s) begin
                udf_d = 1'b1;
            end else begin
                sp_d = sp_q - SP_ONE;
            end
        end else begin
            sp_d = sp_q;
        end
    end

    // Pointer and sticky flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= SP_ZERO;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Entry storage; contents are don't-care after reset, so only writes are gated.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_q[wr_idx_s] <= push_addr;
        end
    end

    assign top_addr  = empty_s ? '0 : mem_q[top_idx_s];
    assign count     = sp_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// Directed bench for ret_stack_ctrl: expected states are queued as stimulus is
// driven and compared at the next mid-cycle sample point.
module tb_ret_stack_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 19;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_addr;
    logic          flush;
    logic          clr_err;
    logic [AW-1:0] top_addr;
    logic [3:0]    count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         tag;
        logic [AW-1:0] top;
        logic [3:0]    cnt;
        logic          emp;
        logic          ful;
        logic          ovf;
        logic          udf;
    } exp_t;

    exp_t sb_q[$];

    ret_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .flush     (flush),
        .clr_err   (clr_err),
        .top_addr  (top_addr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_state(input string tag, input logic [AW-1:0] top,
                                input logic [3:0] cnt, input logic emp, input logic ful,
                                input logic ovf, input logic udf);
        exp_t e;
        e.tag = tag; e.top = top; e.cnt = cnt;
        e.emp = emp; e.ful = ful; e.ovf = ovf; e.udf = udf;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string tag, input string field,
                       input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, "top_addr",  top_addr,               e.top);
            chk(e.tag, "count",     {15'd0, count},         {15'd0, e.cnt});
            chk(e.tag, "empty",     {18'd0, empty},         {18'd0, e.emp});
            chk(e.tag, "full",      {18'd0, full},          {18'd0, e.ful});
            chk(e.tag, "overflow",  {18'd0, overflow},      {18'd0, e.ovf});
            chk(e.tag, "underflow", {18'd0, underflow},     {18'd0, e.udf});
        end
    endtask

    // One clock cycle: drive, sample queued expectations mid-cycle, then take the edge.
    task automatic cyc(input logic p, input logic o, input logic [AW-1:0] a,
                       input logic f, input logic c, input logic r);
        push = p; pop = o; push_addr = a; flush = f; clr_err = c; rst = r;
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; push_addr = '0; flush = 1'b0; clr_err = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset, then three pushes
        cyc(1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b1);
        expect_state("reset", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 19'h00010, 1'b0, 1'b0, 1'b0);
        expect_state("push1", 19'h00010, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 19'h00020, 1'b0, 1'b0, 1'b0);
        expect_state("push2", 19'h00020, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 19'h00030, 1'b0, 1'b0, 1'b0);

        // Pops: top reads the popped value during each pop cycle
        expect_state("pop1_top", 19'h00030, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 19'h0, 1'b0, 1'b0, 1'b0);
        expect_state("pop2_top", 19'h00020, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 19'h0, 1'b0, 1'b0, 1'b0);
        expect_state("pop3_top", 19'h00010, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 19'h0, 1'b0, 1'b0, 1'b0);
        expect_state("emptied", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 19'h0, 1'b0, 1'b0, 1'b0);
        expect_state("underflow", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 19'h0, 1'b0, 1'b1, 1'b0);
        expect_state("udf_clr", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill to DEPTH, then one push too many
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, 1'b0, 19'(i), 1'b0, 1'b0, 1'b0);
            expect_state($sformatf("fill%0d", i), 19'(i), 4'(i), 1'b0, (i == DEPTH), 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, 19'h9, 1'b0, 1'b0, 1'b0);
        expect_state("overflow", 19'h8, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 19'h0, 1'b0, 1'b1, 1'b0);
        expect_state("ovf_clr", 19'h8, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);

        // Tail-call while full replaces the top without raising overflow
        cyc(1'b1, 1'b1, 19'h12345, 1'b0, 1'b0, 1'b0);
        expect_state("tail_full", 19'h12345, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 19'h0, 1'b1, 1'b0, 1'b0);
        expect_state("flush_full", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Tail-call with 0xA, 0xB on the stack
        cyc(1'b1, 1'b0, 19'h0000A, 1'b0, 1'b0, 1'b0);
        expect_state("pushA", 19'h0000A, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 19'h0000B, 1'b0, 1'b0, 1'b0);
        expect_state("tail_old_top", 19'h0000B, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 19'h7FFFF, 1'b0, 1'b0, 1'b0);
        expect_state("tail_new_top", 19'h7FFFF, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 19'h0, 1'b0, 1'b0, 1'b0);
        expect_state("tail_below", 19'h0000A, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 19'h0, 1'b0, 1'b0, 1'b0);
        expect_state("tail_drained", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Push+pop on empty: push happens, underflow is flagged
        cyc(1'b1, 1'b1, 19'h00005, 1'b0, 1'b0, 1'b0);
        expect_state("pp_empty", 19'h00005, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Flush together with push, flags kept; then reset with a push pending
        cyc(1'b1, 1'b0, 19'h00100, 1'b0, 1'b0, 1'b0);
        expect_state("push_udf", 19'h00100, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 19'h00200, 1'b1, 1'b0, 1'b0);
        expect_state("flush_push", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 19'h00400, 1'b0, 1'b0, 1'b1);
        expect_state("rst_mid", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Underflow set wins over a simultaneous clr_err
        cyc(1'b0, 1'b1, 19'h0, 1'b0, 1'b1, 1'b0);
        expect_state("set_beats_clr", 19'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ret_stack_ctrl.md
# ret_stack_ctrl

Hardware return-address stack controller for the 19-bit CPU. It holds call return addresses pushed by the call opcode (push) and supplies the return target for the return opcode (pop). It sits beside the PC-select logic: the control decoder drives `push`/`pop`, and `top_addr` feeds the jump-target mux for `jump == 2'b11`. Overflow, underflow, fill level and a flush path are handled here rather than in the PC logic.

## Interface
Parameters:
- `DEPTH`, default 8. Number of stack entries. Must be a power of two, minimum 2.
- `AW`, default 19. Address width; matches the CPU word width.

Ports (clock and reset first):
- `clk` — input, 1 bit. Single clock; all state updates on the rising edge.
- `rst` — input, 1 bit. Synchronous, active-high reset.
- `push` — input, 1 bit. Push `push_addr` this cycle (call).
- `pop` — input, 1 bit. Pop the top entry this cycle (return).
- `push_addr` — input, AW bits. Return address to store (PC+1 from the datapath).
- `flush` — input, 1 bit. Discard all entries; sticky error flags are kept.
- `clr_err` — input, 1 bit. Clear the `overflow` and `underflow` flags.
- `top_addr` — output, AW bits. Combinational value of the current top entry; 0 when empty.
- `count` — output, $clog2(DEPTH+1) bits. Number of valid entries.
- `empty` — output, 1 bit. High when `count == 0`.
- `full` — output, 1 bit. High when `count == DEPTH`.
- `overflow` — output, 1 bit. Sticky: a push was dropped because the stack was full.
- `underflow` — output, 1 bit. Sticky: a pop was issued while the stack was empty.

## Operation
- Storage is a DEPTH × AW register array plus a stack pointer `sp` of width $clog2(DEPTH+1); `count == sp`.
- Reset values: `sp = 0`, `overflow = 0`, `underflow = 0`. Array contents are don't-care. Resulting outputs: `top_addr = 0`, `empty = 1`, `full = 0`, `count = 0`.
- Priority, highest first: `rst` > `flush` > push/pop. `clr_err` is evaluated in parallel with push/pop. If the same cycle also sets a flag, the set wins.
- `flush`: `sp` ← 0 and any push/pop in the same cycle is ignored. Flags are unchanged unless `clr_err` is also high.
- Push only, not full: `mem[sp]` ← `push_addr`; `sp` ← `sp+1`.
- Push only, full: the entry is dropped, `sp` is unchanged and `overflow` ← 1. There is no wrap and the oldest entry is not overwritten.
- Pop only, not empty: `sp` ← `sp-1`. `top_addr` shows the popped value during the pop cycle.
- Pop only, empty: `sp` stays 0 and `underflow` ← 1.
- Push and pop together, not empty (tail-call): `mem[sp-1]` ← `push_addr`; `sp` is unchanged. `top_addr` shows the old top during the cycle. This applies even when full, and does not set `overflow`.
- Push and pop together, empty: the push is performed (`mem[0]` ← `push_addr`, `sp` ← 1) and `underflow` ← 1.
- `top_addr = (sp == 0) ? 0 : mem[sp-1]`. This is purely combinational from registered state, with no path from the `push`/`pop` inputs.
- Arithmetic: `sp` never leaves the range 0..DEPTH. No modular wrap is permitted.

## Timing
- Pop latency: 0 cycles. The return target is valid in the same cycle `pop` is asserted, so the PC mux can use it directly.
- Push latency: 1 cycle. The pushed value appears on `top_addr`, and in `count`/`full`, the cycle after the push edge.
- `empty`, `full` and `count` update one cycle after the causing edge. Flags assert the cycle after the offending request.
- There is no handshake. Requests are single-cycle strobes, and every request is consumed or rejected in its own cycle.
- When `rst` or `flush` is asserted in the middle of a push/pop sequence, it takes effect at that edge. No partial write to `mem` occurs in that cycle.
- Consecutive push and pop cycles back-to-back are fully supported, with no bubbles.

## Test plan
- **Reset, then push sequence:** apply reset; push 0x00010, 0x00020, 0x00030 on consecutive cycles. Required: `count = 3`, `top_addr = 0x00030`, `empty = 0`.
- **Pop ordering and underflow:** starting from the state above, pop 3 times. Required: `top_addr` reads 0x00030, 0x00020, 0x00010 in the respective pop cycles; then `empty = 1` and `top_addr = 0`. A 4th pop: `underflow = 1` next cycle, `count = 0`.
- **Overflow:** with `DEPTH = 8`, push 0x1..0x9. Required: `full = 1` after the 8th push. The 9th push sets `overflow`, `count` stays 8 and `top_addr` stays 0x8. `clr_err` clears `overflow`.
- **Tail-call:** from the state with 0xA then 0xB pushed, assert push+pop with 0x7FFFF. Required: `top_addr` shows 0xB that cycle; next cycle `top_addr = 0x7FFFF` and `count = 2`.
- **Push+pop on empty:** from empty, assert push+pop with 0x5. Required: `count = 1`, `top_addr = 0x5`, `underflow = 1`.
- **Flush and reset mid-sequence:** push 2 entries with `underflow` set, then assert `flush` together with push. Required: `count = 0`, no entry written, `underflow` still 1. A following `rst`: all flags 0 and `empty = 1`.
